// File: rtl/core_dmem_pkg.sv
// Shared definitions for the core data-memory arbiter: arbitration state,
// read-return owner encoding, default widths and the counter-width helper.
package core_dmem_pkg;

  localparam int unsigned DEF_ADDR_WIDTH    = 8;
  localparam int unsigned DEF_DATA_WIDTH    = 8;
  localparam int unsigned DEF_HOST_MAX_WAIT = 4;

  // OPEN: normal core-priority arbitration; HOST_LOCKED: host owns the RAM
  typedef enum logic {
    OPEN        = 1'b0,
    HOST_LOCKED = 1'b1
  } arb_state_e;

  // Which requester the read data returning next cycle belongs to
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_HOST = 2'd2
  } owner_e;

  // Bits needed to count 0..max_wait inclusive
  function automatic int unsigned cnt_width(input int unsigned max_wait);
    return $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/core_dmem_arbiter.sv
// Arbitrates the single-port data RAM between the core load/store path and
// an external host port. The core has default priority; a starvation counter
// forces a host win after HOST_MAX_WAIT refused cycles, and a host lock keeps
// ownership across a read-modify-write.
//
// Ports:
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   i_core_*  / o_core_*       core request (req/we/addr/wdata), grant, read return
//   i_host_*  / o_host_*       host request (req/we/lock/addr/wdata), grant, read return
//   o_mem_*   / i_mem_rdata    RAM port; read data valid one cycle after a read enable
module core_dmem_arbiter
  import core_dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned HOST_MAX_WAIT = DEF_HOST_MAX_WAIT
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,

  input  logic                  i_core_req,
  input  logic                  i_core_we,
  input  logic [ADDR_WIDTH-1:0] i_core_addr,
  input  logic [DATA_WIDTH-1:0] i_core_wdata,
  output logic                  o_core_gnt,
  output logic                  o_core_rvalid,
  output logic [DATA_WIDTH-1:0] o_core_rdata,

  input  logic                  i_host_req,
  input  logic                  i_host_we,
  input  logic                  i_host_lock,
  input  logic [ADDR_WIDTH-1:0] i_host_addr,
  input  logic [DATA_WIDTH-1:0] i_host_wdata,
  output logic                  o_host_gnt,
  output logic                  o_host_rvalid,
  output logic [DATA_WIDTH-1:0] o_host_rdata,

  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  localparam int unsigned CNT_W = cnt_width(HOST_MAX_WAIT);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(HOST_MAX_WAIT);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  owner_e           owner_q, owner_d;
  logic             rd_q, rd_d;

  logic             core_gnt;
  logic             host_gnt;

  // Grant decision, combinational from requests and registered state.
  // Gated by reset so nothing is granted while the block is held in reset.
  always_comb begin
    core_gnt = 1'b0;
    host_gnt = 1'b0;
    if (i_rst_n) begin
      if (state_q == HOST_LOCKED) begin
        host_gnt = i_host_req;
      end else if (i_host_req && (wait_cnt_q == WAIT_MAX)) begin
        host_gnt = 1'b1;
      end else if (i_core_req) begin
        core_gnt = 1'b1;
      end else begin
        host_gnt = i_host_req;
      end
    end
  end

  // Next-state: lock state, starvation counter, read-return tag
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    owner_d    = OWN_NONE;
    rd_d       = 1'b0;

    if (state_q == OPEN) begin
      if (host_gnt && i_host_lock) begin
        state_d = HOST_LOCKED;
      end
    end else begin
      // Lock ends when the host releases it on a grant or stops requesting
      if (!i_host_req || (host_gnt && !i_host_lock)) begin
        state_d = OPEN;
      end
    end

    if (!i_host_req || host_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WAIT_MAX) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end

    if (core_gnt) begin
      owner_d = OWN_CORE;
      rd_d    = ~i_core_we;
    end else if (host_gnt) begin
      owner_d = OWN_HOST;
      rd_d    = ~i_host_we;
    end
  end

  // State registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= OPEN;
      wait_cnt_q <= '0;
      owner_q    <= OWN_NONE;
      rd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      owner_q    <= owner_d;
      rd_q       <= rd_d;
    end
  end

  // RAM port mux: granted requester's signals, all zero when idle
  always_comb begin
    o_mem_en    = core_gnt | host_gnt;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (core_gnt) begin
      o_mem_we    = i_core_we;
      o_mem_addr  = i_core_addr;
      o_mem_wdata = i_core_wdata;
    end else if (host_gnt) begin
      o_mem_we    = i_host_we;
      o_mem_addr  = i_host_addr;
      o_mem_wdata = i_host_wdata;
    end
  end

  assign o_core_gnt = core_gnt;
  assign o_host_gnt = host_gnt;

  // Read return steered by the registered tag; data forced to 0 otherwise
  assign o_core_rvalid = rd_q && (owner_q == OWN_CORE);
  assign o_host_rvalid = rd_q && (owner_q == OWN_HOST);
  assign o_core_rdata  = o_core_rvalid ? i_mem_rdata : '0;
  assign o_host_rdata  = o_host_rvalid ? i_mem_rdata : '0;

endmodule

// File: tb/tb_core_dmem_arbiter.sv
// Bench for core_dmem_arbiter: directed scenarios followed by randomized
// handshake-legal traffic, checked every cycle against a behavioural model.
module tb_core_dmem_arbiter;

  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int MAXW = 4;

  logic          clk;
  logic          rst_n;
  logic          core_req, core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic          core_gnt, core_rvalid;
  logic [DW-1:0] core_rdata;
  logic          host_req, host_we, host_lock;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt, host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] ram_rdata;

  core_dmem_arbiter #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .HOST_MAX_WAIT(MAXW)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_core_req   (core_req),
    .i_core_we    (core_we),
    .i_core_addr  (core_addr),
    .i_core_wdata (core_wdata),
    .o_core_gnt   (core_gnt),
    .o_core_rvalid(core_rvalid),
    .o_core_rdata (core_rdata),
    .i_host_req   (host_req),
    .i_host_we    (host_we),
    .i_host_lock  (host_lock),
    .i_host_addr  (host_addr),
    .i_host_wdata (host_wdata),
    .o_host_gnt   (host_gnt),
    .o_host_rvalid(host_rvalid),
    .o_host_rdata (host_rdata),
    .o_mem_en     (mem_en),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .i_mem_rdata  (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM driven by the arbiter
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        ram_rdata     <= ram[mem_addr];
    end
  end

  int n_checks;
  int n_errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: how long the host has been refused, whether it holds
  // the lock, which read returns next cycle and with what data.
  bit            m_locked;
  int            m_waited;
  bit            m_pend_c, m_pend_h;
  logic [DW-1:0] m_pend_d;
  logic [DW-1:0] shadow [256];

  always @(negedge clk) begin
    logic          ecg, ehg, emw;
    logic [AW-1:0] ema;
    logic [DW-1:0] emd;
    if (!rst_n) begin
      chk("rst_core_gnt",    32'(core_gnt),    0);
      chk("rst_host_gnt",    32'(host_gnt),    0);
      chk("rst_core_rvalid", 32'(core_rvalid), 0);
      chk("rst_host_rvalid", 32'(host_rvalid), 0);
      chk("rst_core_rdata",  32'(core_rdata),  0);
      chk("rst_host_rdata",  32'(host_rdata),  0);
      chk("rst_mem_out",     {14'd0, mem_en, mem_we, mem_addr, mem_wdata}, 0);
      m_locked = 1'b0;
      m_waited = 0;
      m_pend_c = 1'b0;
      m_pend_h = 1'b0;
      m_pend_d = '0;
    end else begin
      ecg = 1'b0;
      ehg = 1'b0;
      if (m_locked)                             ehg = host_req;
      else if (host_req && m_waited >= MAXW)    ehg = 1'b1;
      else if (core_req)                        ecg = 1'b1;
      else                                      ehg = host_req;

      emw = ecg ? core_we    : (ehg ? host_we    : 1'b0);
      ema = ecg ? core_addr  : (ehg ? host_addr  : '0);
      emd = ecg ? core_wdata : (ehg ? host_wdata : '0);

      chk("core_gnt",    32'(core_gnt),    32'(ecg));
      chk("host_gnt",    32'(host_gnt),    32'(ehg));
      chk("mem_en",      32'(mem_en),      32'(ecg | ehg));
      chk("mem_we",      32'(mem_we),      32'(emw));
      chk("mem_addr",    32'(mem_addr),    32'(ema));
      chk("mem_wdata",   32'(mem_wdata),   32'(emd));
      chk("core_rvalid", 32'(core_rvalid), 32'(m_pend_c));
      chk("host_rvalid", 32'(host_rvalid), 32'(m_pend_h));
      chk("core_rdata",  32'(core_rdata),  m_pend_c ? 32'(m_pend_d) : 0);
      chk("host_rdata",  32'(host_rdata),  m_pend_h ? 32'(m_pend_d) : 0);
      chk("dual_rvalid", 32'(core_rvalid & host_rvalid), 0);

      m_pend_c = ecg && !core_we;
      m_pend_h = ehg && !host_we;
      if (m_pend_c) m_pend_d = shadow[core_addr];
      if (m_pend_h) m_pend_d = shadow[host_addr];
      if (ecg && core_we) shadow[core_addr] = core_wdata;
      if (ehg && host_we) shadow[host_addr] = host_wdata;

      if (host_req && !ehg) m_waited = (m_waited + 1 > MAXW) ? MAXW : m_waited + 1;
      else                  m_waited = 0;

      m_locked = m_locked ? (host_req && host_lock) : (ehg && host_lock);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic cg, hg;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_lock = 1'b0; host_addr = '0; host_wdata = '0;
    ram_rdata = '0;
    for (int i = 0; i < 256; i++) ram[i] = 8'(i * 7 + 1);
    ram[8'h10] = 8'h5A;
    ram[8'h20] = 8'h11;
    for (int i = 0; i < 256; i++) shadow[i] = ram[i];

    // Reset with a core request pending: nothing may be granted
    core_req = 1'b1; core_addr = 8'h10;
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold_gnt", 32'(core_gnt), 0);
    end
    next_cycle();
    rst_n = 1'b1;

    // 1: core-only read of 0x10
    @(negedge clk);
    chk("t1_gnt",  32'(core_gnt), 1);
    chk("t1_addr", 32'(mem_addr), 'h10);
    next_cycle();
    core_req = 1'b0;
    @(negedge clk);
    chk("t1_rvalid",      32'(core_rvalid), 1);
    chk("t1_rdata",       32'(core_rdata),  'h5A);
    chk("t1_host_rvalid", 32'(host_rvalid), 0);

    // 2: contention, host wins on its fifth cycle of request
    next_cycle();
    core_req = 1'b1; core_we = 1'b0; core_addr = 8'h02;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t2_core_gnt", 32'(core_gnt), 32'(c < 4));
      chk("t2_host_gnt", 32'(host_gnt), 32'(c == 4));
      next_cycle();
    end
    host_req = 1'b0;
    @(negedge clk);
    chk("t2_host_rvalid", 32'(host_rvalid), 1);
    chk("t2_host_rdata",  32'(host_rdata),  'h5A);

    // 3: locked read-modify-write of 0x20 under constant core traffic
    next_cycle();
    host_req = 1'b1; host_lock = 1'b1; host_we = 1'b0; host_addr = 8'h20;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t3_host_rd_gnt", 32'(host_gnt), 32'(c == 4));
      if (c == 4) chk("t3_core_refused_rd", 32'(core_gnt), 0);
      next_cycle();
    end
    host_we = 1'b1; host_wdata = 8'h33; host_lock = 1'b0;
    @(negedge clk);
    chk("t3_host_wr_gnt",     32'(host_gnt), 1);
    chk("t3_core_refused_wr", 32'(core_gnt), 0);
    chk("t3_host_rd_data",    32'(host_rdata), 'h11);
    next_cycle();
    host_req = 1'b0; host_we = 1'b0;
    @(negedge clk);
    chk("t3_core_after", 32'(core_gnt), 1);
    next_cycle();
    core_addr = 8'h20;
    @(negedge clk);
    next_cycle();
    core_req = 1'b0;
    @(negedge clk);
    chk("t3_core_rvalid", 32'(core_rvalid), 1);
    chk("t3_core_rdata",  32'(core_rdata),  'h33);

    // 4: withdrawn host request leaves no credit behind
    next_cycle();
    core_req = 1'b1; core_addr = 8'h03;
    host_req = 1'b1; host_addr = 8'h30;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("t4_host_nogrant", 32'(host_gnt), 0);
      next_cycle();
    end
    host_req = 1'b0;
    @(negedge clk);
    chk("t4_host_dropped", 32'(host_gnt), 0);
    next_cycle();
    host_req = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t4_host_rewait", 32'(host_gnt), 32'(c == 4));
      next_cycle();
    end
    host_req = 1'b0; core_req = 1'b0;

    // 5: reset during an outstanding core read
    @(negedge clk);
    next_cycle();
    core_req = 1'b1; core_addr = 8'h10;
    @(negedge clk);
    chk("t5_gnt", 32'(core_gnt), 1);
    next_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rvalid_rst", 32'(core_rvalid), 0);
    chk("t5_mem_en_rst", 32'(mem_en), 0);
    next_cycle();
    core_req = 1'b0;
    @(negedge clk);
    chk("t5_rvalid_rst2", 32'(core_rvalid), 0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_rvalid_after", 32'(core_rvalid), 0);
    next_cycle();

    // 6: alternating core write / host read of 0x01
    core_req = 1'b1; core_we = 1'b1; core_addr = 8'h01; core_wdata = 8'hA5;
    @(negedge clk);
    chk("t6_core_gnt", 32'(core_gnt), 1);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      core_req = 1'b0;
      host_req = 1'b1; host_we = 1'b0; host_addr = 8'h01;
      @(negedge clk);
      chk("t6_host_gnt", 32'(host_gnt), 1);
      next_cycle();
      host_req = 1'b0;
      core_req = 1'b1;
      @(negedge clk);
      chk("t6_host_rvalid", 32'(host_rvalid), 1);
      chk("t6_host_rdata",  32'(host_rdata),  'hA5);
      chk("t6_core_rvalid", 32'(core_rvalid), 0);
      chk("t6_core_regnt",  32'(core_gnt),    1);
    end
    next_cycle();
    core_req = 1'b0; core_we = 1'b0;

    // Randomized, handshake-respecting traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      cg = core_gnt;
      hg = host_gnt;
      next_cycle();
      rst_n = ($urandom_range(0, 249) != 0);
      if (!core_req || cg || $urandom_range(0, 15) == 0) begin
        core_req   = ($urandom_range(0, 3) != 0);
        core_we    = $urandom_range(0, 1) != 0;
        core_addr  = 8'($urandom_range(0, 15));
        core_wdata = 8'($urandom);
      end
      if (!host_req || hg || $urandom_range(0, 15) == 0) begin
        host_req   = ($urandom_range(0, 1) != 0);
        host_we    = $urandom_range(0, 1) != 0;
        host_lock  = ($urandom_range(0, 2) == 0);
        host_addr  = 8'($urandom_range(0, 15));
        host_wdata = 8'($urandom);
      end
    end
    rst_n = 1'b1;
    core_req = 1'b0;
    host_req = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
